// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcodes, functs,
// state encodings, ALU/PC-source codes and the control-word payload.
package mc_ctrl_fsm_pkg;

    localparam int unsigned OP_W = 6;
    localparam logic [4:0]  RA_REG = 5'd31;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_JR    = 6'h08;
    localparam logic [OP_W-1:0] FN_ADD   = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB   = 6'h22;
    localparam logic [OP_W-1:0] FN_AND   = 6'h24;
    localparam logic [OP_W-1:0] FN_OR    = 6'h25;
    localparam logic [OP_W-1:0] FN_XOR   = 6'h26;
    localparam logic [OP_W-1:0] FN_NOR   = 6'h27;
    localparam logic [OP_W-1:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_LUI = 4'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_t;

    typedef enum logic [3:0] {
        IC_RTYPE = 4'd0,
        IC_JR    = 4'd1,
        IC_J     = 4'd2,
        IC_JAL   = 4'd3,
        IC_BEQ   = 4'd4,
        IC_BNE   = 4'd5,
        IC_LW    = 4'd6,
        IC_SW    = 4'd7,
        IC_IALU  = 4'd8,
        IC_ILL   = 4'd9
    } instr_class_t;

    typedef struct packed {
        logic       pc_we;
        pc_src_t    pc_src;
        logic       ir_we;
        logic       mem_read;
        logic       mem_we;
        logic       iord;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Decoded-instruction inputs and datapath control outputs of the control FSM.
interface mc_ctrl_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             ir_we;
    logic             mem_read;
    logic             mem_we;
    logic             iord;
    logic             reg_we;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic [2:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        output opcode, funct, zero, mem_ready,
        input  pc_we, pc_src, ir_we, mem_read, mem_we, iord, reg_we, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, state, illegal, instret
    );

    modport slave (
        input  opcode, funct, zero, mem_ready,
        output pc_we, pc_src, ir_we, mem_read, mem_we, iord, reg_we, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, state, illegal, instret
    );
endinterface

// File: rtl/mc_ctrl_fsm_alu_ctrl_dec.sv
// Instruction decoder: classifies opcode/funct and picks the EX-stage ALU operation.
module mc_ctrl_fsm_alu_ctrl_dec
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output alu_op_t      alu_op,
    output instr_class_t iclass,
    output logic         legal
);

    always_comb begin
        alu_op = ALU_ADD;
        iclass = IC_ILL;
        case (opcode)
            OP_RTYPE: begin
                iclass = IC_RTYPE;
                case (funct)
                    FN_JR:   iclass = IC_JR;
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: iclass = IC_ILL;
                endcase
            end
            OP_J:    iclass = IC_J;
            OP_JAL:  iclass = IC_JAL;
            OP_BEQ:  begin iclass = IC_BEQ;  alu_op = ALU_SUB; end
            OP_BNE:  begin iclass = IC_BNE;  alu_op = ALU_SUB; end
            OP_ADDI: iclass = IC_IALU;
            OP_ORI:  begin iclass = IC_IALU; alu_op = ALU_OR;  end
            OP_LUI:  begin iclass = IC_IALU; alu_op = ALU_LUI; end
            OP_LW:   iclass = IC_LW;
            OP_SW:   iclass = IC_SW;
            default: iclass = IC_ILL;
        endcase
    end

    assign legal = (iclass != IC_ILL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, memory and
// write-back, driving the datapath muxes and counting retired instructions.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    mc_ctrl_fsm_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] instret_q;
    alu_op_t          ex_alu_op;
    instr_class_t     iclass;
    logic             legal;
    ctrl_t            ctl;
    ctrl_t            ctl_out;
    logic             retire;

    mc_ctrl_fsm_alu_ctrl_dec u_dec (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .alu_op (ex_alu_op),
        .iclass (iclass),
        .legal  (legal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Next state, control word and retire strobe for the current step.
    always_comb begin
        state_d = S_IF;
        ctl     = '0;
        retire  = 1'b0;
        case (state_q)
            S_IF: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'd1;
                ctl.alu_op    = ALU_ADD;
                state_d       = S_IF;
                if (bus.mem_ready) begin
                    ctl.ir_we  = 1'b1;
                    ctl.pc_we  = 1'b1;
                    ctl.pc_src = PC_ALU;
                    state_d    = S_ID;
                end
            end
            S_ID: begin
                // Branch target is precomputed here regardless of instruction.
                ctl.alu_src_b = 2'd3;
                ctl.alu_op    = ALU_ADD;
                state_d       = S_EX;
                if (!legal) begin
                    ctl.illegal = 1'b1;
                    state_d     = S_IF;
                end else begin
                    case (iclass)
                        IC_J, IC_JAL: begin
                            ctl.pc_we  = 1'b1;
                            ctl.pc_src = PC_JUMP;
                            state_d    = S_IF;
                            retire     = 1'b1;
                            if (iclass == IC_JAL) begin
                                ctl.reg_we     = 1'b1;
                                ctl.reg_dst    = 2'd2;
                                ctl.mem_to_reg = 2'd2;
                            end
                        end
                        IC_JR: begin
                            ctl.pc_we  = 1'b1;
                            ctl.pc_src = PC_REG;
                            state_d    = S_IF;
                            retire     = 1'b1;
                        end
                        default: state_d = S_EX;
                    endcase
                end
            end
            S_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'd2;
                ctl.alu_op    = ex_alu_op;
                case (iclass)
                    IC_RTYPE: begin
                        ctl.alu_src_b = 2'd0;
                        state_d       = S_WB;
                    end
                    IC_BEQ, IC_BNE: begin
                        ctl.alu_src_b = 2'd0;
                        ctl.pc_src    = PC_BRANCH;
                        ctl.pc_we     = (iclass == IC_BEQ) ? bus.zero : ~bus.zero;
                        state_d       = S_IF;
                        retire        = 1'b1;
                    end
                    IC_LW, IC_SW: state_d = S_MEM;
                    IC_IALU:      state_d = S_WB;
                    default:      state_d = S_IF;
                endcase
            end
            S_MEM: begin
                ctl.iord = 1'b1;
                state_d  = S_MEM;
                if (iclass == IC_SW) ctl.mem_we   = 1'b1;
                else                 ctl.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    if (iclass == IC_SW) begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                ctl.reg_we = 1'b1;
                retire     = 1'b1;
                state_d    = S_IF;
                if (iclass == IC_LW) begin
                    ctl.mem_to_reg = 2'd1;
                    ctl.reg_dst    = 2'd0;
                end else if (iclass == IC_RTYPE) begin
                    ctl.reg_dst = 2'd1;
                end
            end
            default: state_d = S_IF;
        endcase
    end

    // Reset forces every control output low, aborting any in-flight write.
    assign ctl_out = rst ? ctl : '0;

    assign bus.pc_we      = ctl_out.pc_we;
    assign bus.pc_src     = ctl_out.pc_src;
    assign bus.ir_we      = ctl_out.ir_we;
    assign bus.mem_read   = ctl_out.mem_read;
    assign bus.mem_we     = ctl_out.mem_we;
    assign bus.iord       = ctl_out.iord;
    assign bus.reg_we     = ctl_out.reg_we;
    assign bus.reg_dst    = ctl_out.reg_dst;
    assign bus.mem_to_reg = ctl_out.mem_to_reg;
    assign bus.alu_src_a  = ctl_out.alu_src_a;
    assign bus.alu_src_b  = ctl_out.alu_src_b;
    assign bus.alu_op     = ctl_out.alu_op;
    assign bus.illegal    = ctl_out.illegal;
    assign bus.state      = state_q;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: directed instruction sequences push
// hand-computed per-cycle control words; a monitor pops and compares them.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic [2:0]  st;
        logic        pc_we;
        logic [1:0]  pc_src;
        logic        ir_we;
        logic        mem_read;
        logic        mem_we;
        logic        iord;
        logic        reg_we;
        logic [1:0]  reg_dst;
        logic [1:0]  mem_to_reg;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [3:0]  alu_op;
        logic        illegal;
        logic [31:0] instret;
    } exp_t;

    localparam logic [3:0] A_ADD = 4'd0;
    localparam logic [3:0] A_SUB = 4'd1;
    localparam logic [3:0] A_OR  = 4'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [5:0] cur_op = 6'h00;
    logic [5:0] cur_fn = 6'h00;

    exp_t  exp_q[$];
    string lbl_q[$];
    int    total = 0;
    int    bad   = 0;

    mc_ctrl_fsm_if #(.CNT_W(32)) bus();

    mc_ctrl_fsm #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] st, input logic pcwe, input logic [1:0] pcs,
                                input logic irwe, input logic mrd, input logic mwe, input logic iord,
                                input logic rwe, input logic [1:0] rdst, input logic [1:0] m2r,
                                input logic asa, input logic [1:0] asb, input logic [3:0] aop,
                                input logic ill, input logic [31:0] cnt);
        exp_t e;
        e.st = st; e.pc_we = pcwe; e.pc_src = pcs; e.ir_we = irwe; e.mem_read = mrd;
        e.mem_we = mwe; e.iord = iord; e.reg_we = rwe; e.reg_dst = rdst; e.mem_to_reg = m2r;
        e.alu_src_a = asa; e.alu_src_b = asb; e.alu_op = aop; e.illegal = ill; e.instret = cnt;
        return e;
    endfunction

    function automatic exp_t e_if(input logic mr, input logic [31:0] cnt);
        return mk(3'd0, mr, 2'd0, mr, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, A_ADD, 1'b0, cnt);
    endfunction

    function automatic exp_t e_id(input logic [31:0] cnt);
        return mk(3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd3, A_ADD, 1'b0, cnt);
    endfunction

    function automatic exp_t e_zero();
        return mk(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 32'd0);
    endfunction

    // One clock of stimulus; the expected control word for this cycle is queued.
    task automatic step(input string lbl, input logic r, input logic z, input logic mr, input exp_t e);
        rst           = r;
        bus.zero      = z;
        bus.mem_ready = mr;
        bus.opcode    = cur_op;
        bus.funct     = cur_fn;
        exp_q.push_back(e);
        lbl_q.push_back(lbl);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string l;
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            g.st = bus.state; g.pc_we = bus.pc_we; g.pc_src = bus.pc_src; g.ir_we = bus.ir_we;
            g.mem_read = bus.mem_read; g.mem_we = bus.mem_we; g.iord = bus.iord;
            g.reg_we = bus.reg_we; g.reg_dst = bus.reg_dst; g.mem_to_reg = bus.mem_to_reg;
            g.alu_src_a = bus.alu_src_a; g.alu_src_b = bus.alu_src_b; g.alu_op = bus.alu_op;
            g.illegal = bus.illegal; g.instret = bus.instret;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL %s: got state=%0d ctl=%h instret=%0d, want state=%0d ctl=%h instret=%0d",
                         l, g.st, g[54:32], g.instret, e.st, e[54:32], e.instret);
            end
        end
    end

    initial begin
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Held in reset: all outputs low even with mem_ready high.
        step("reset0", 0, 0, 1, e_zero());
        step("reset1", 0, 0, 1, e_zero());

        cur_op = 6'h00; cur_fn = 6'h20;
        step("add_if", 1, 0, 1, e_if(1, 0));
        step("add_id", 1, 0, 0, e_id(0));
        step("add_ex", 1, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_ADD, 0, 0));
        step("add_wb", 1, 0, 0, mk(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, A_ADD, 0, 0));

        cur_op = 6'h0D; cur_fn = 6'h00;
        step("ori_if", 1, 0, 1, e_if(1, 1));
        step("ori_id", 1, 0, 0, e_id(1));
        step("ori_ex", 1, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, A_OR, 0, 1));
        step("ori_wb", 1, 0, 0, mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 1));

        cur_op = 6'h04;
        step("beq1_if", 1, 0, 1, e_if(1, 2));
        step("beq1_id", 1, 0, 0, e_id(2));
        step("beq1_ex", 1, 1, 0, mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_SUB, 0, 2));
        step("beq0_if", 1, 0, 1, e_if(1, 3));
        step("beq0_id", 1, 0, 0, e_id(3));
        step("beq0_ex", 1, 0, 0, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_SUB, 0, 3));

        cur_op = 6'h23;
        step("lw_if_w0", 1, 0, 0, e_if(0, 4));
        step("lw_if_w1", 1, 0, 0, e_if(0, 4));
        step("lw_if",    1, 0, 1, e_if(1, 4));
        step("lw_id",    1, 0, 0, e_id(4));
        step("lw_ex",    1, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, A_ADD, 0, 4));
        for (int i = 0; i < 3; i++)
            step("lw_mem_w", 1, 0, 0, mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 4));
        step("lw_mem",   1, 0, 1, mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 4));
        step("lw_wb",    1, 0, 0, mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, A_ADD, 0, 4));

        cur_op = 6'h03;
        step("jal_if", 1, 0, 1, e_if(1, 5));
        step("jal_id", 1, 0, 0, mk(1, 1, 2, 0, 0, 0, 0, 1, 2, 2, 0, 3, A_ADD, 0, 5));

        cur_op = 6'h00; cur_fn = 6'h08;
        step("jr_if", 1, 0, 1, e_if(1, 6));
        step("jr_id", 1, 0, 0, mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 6));

        cur_op = 6'h3F; cur_fn = 6'h00;
        step("ill_if",  1, 0, 1, e_if(1, 7));
        step("ill_id",  1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 1, 7));
        step("ill_ret", 1, 0, 0, e_if(0, 7));

        // sw stalled in MEM, then reset mid-access.
        cur_op = 6'h2B;
        step("sw_if",     1, 0, 1, e_if(1, 7));
        step("sw_id",     1, 0, 0, e_id(7));
        step("sw_ex",     1, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, A_ADD, 0, 7));
        step("sw_mem_w",  1, 0, 0, mk(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, A_ADD, 0, 7));
        step("sw_rst",    0, 0, 1, e_zero());
        step("sw_rel_if", 1, 0, 0, e_if(0, 0));
        step("sw2_if",    1, 0, 1, e_if(1, 0));
        step("sw2_id",    1, 0, 0, e_id(0));
        step("sw2_ex",    1, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, A_ADD, 0, 0));
        step("sw2_mem",   1, 0, 1, mk(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, A_ADD, 0, 0));
        step("sw2_done",  1, 0, 0, e_if(0, 1));

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
